// File: rtl/register_file_multiport.sv
// register_file_multiport
// N-read / M-write register file with byte-strobed writes, optional
// same-cycle write->read bypass, an optional hard-wired zero entry and a
// hardware clear sequencer that zeroes every entry after reset or on request.
// The storage array itself has no reset; only the sequencer state does.

module register_file_multiport #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 5,
    parameter int READ_PORTS  = 2,
    parameter int WRITE_PORTS = 1,
    parameter int BYPASS      = 0,
    parameter int ZERO_REG    = 1
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic                                clear_request,
    output logic                                ready,
    input  logic [READ_PORTS*ADDR_WIDTH-1:0]    read_address,
    output logic [READ_PORTS*DATA_WIDTH-1:0]    read_data,
    input  logic [WRITE_PORTS-1:0]              write_enabled,
    input  logic [WRITE_PORTS*DATA_WIDTH/8-1:0] write_strobe,
    input  logic [WRITE_PORTS*ADDR_WIDTH-1:0]   write_address,
    input  logic [WRITE_PORTS*DATA_WIDTH-1:0]   write_data
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int BYTES = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH-1:0] LAST_INDEX = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR  = {ADDR_WIDTH{1'b0}};
    localparam logic [ADDR_WIDTH-1:0] INDEX_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    state_t                  state_r;
    state_t                  state_s;
    logic [ADDR_WIDTH-1:0]   clear_index_r;
    logic [ADDR_WIDTH-1:0]   clear_index_s;
    logic                    ready_r;
    logic                    ready_s;
    logic [DATA_WIDTH-1:0]   mem_r [DEPTH];

    // Overlay the strobed bytes of data onto base; unstrobed bytes keep base.
    // Applying it port by port in ascending order gives the highest port priority.
    function automatic logic [DATA_WIDTH-1:0] merge_bytes(
        input logic [DATA_WIDTH-1:0] base,
        input logic [DATA_WIDTH-1:0] data,
        input logic [BYTES-1:0]      strobe
    );
        logic [DATA_WIDTH-1:0] result;
        result = base;
        for (int b = 0; b < BYTES; b++) begin
            result[b*8 +: 8] = strobe[b] ? data[b*8 +: 8] : base[b*8 +: 8];
        end
        return result;
    endfunction

    // Sequencer state, clear index and ready flag; reset forces a fresh clear.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r       <= CLEAR;
            clear_index_r <= ZERO_ADDR;
            ready_r       <= 1'b0;
        end else begin
            state_r       <= state_s;
            clear_index_r <= clear_index_s;
            ready_r       <= ready_s;
        end
    end

    // Next-state logic: walk every entry once in CLEAR, re-enter CLEAR on request.
    always_comb begin
        state_s       = state_r;
        clear_index_s = clear_index_r;
        ready_s       = ready_r;
        case (state_r)
            CLEAR: begin
                if (clear_index_r == LAST_INDEX) begin
                    state_s       = READY;
                    clear_index_s = ZERO_ADDR;
                    ready_s       = 1'b1;
                end else begin
                    clear_index_s = clear_index_r + INDEX_ONE;
                    ready_s       = 1'b0;
                end
            end
            READY: begin
                if (clear_request) begin
                    state_s       = CLEAR;
                    clear_index_s = ZERO_ADDR;
                    ready_s       = 1'b0;
                end else begin
                    ready_s       = 1'b1;
                end
            end
            default: begin
                state_s       = CLEAR;
                clear_index_s = ZERO_ADDR;
                ready_s       = 1'b0;
            end
        endcase
    end

    assign ready = ready_r;

    // One storage entry per iteration: user writes only while ready, clear
    // writes only in CLEAR, so the two sources never coincide.
    for (genvar e = 0; e < DEPTH; e++) begin : g_entry
        localparam logic [ADDR_WIDTH-1:0] ENTRY = ADDR_WIDTH'(e);
        localparam bit WRITABLE = !((ZERO_REG != 0) && (e == 0));

        logic [DATA_WIDTH-1:0] merged_s;
        logic [DATA_WIDTH-1:0] next_s;
        logic                  hit_s;

        // Merge all write ports addressing this entry, then apply clear.
        always_comb begin
            merged_s = mem_r[e];
            hit_s    = 1'b0;
            for (int p = 0; p < WRITE_PORTS; p++) begin
                hit_s = ready_r && WRITABLE && write_enabled[p] &&
                        (write_address[p*ADDR_WIDTH +: ADDR_WIDTH] == ENTRY);
                merged_s = merge_bytes(merged_s,
                                       write_data[p*DATA_WIDTH +: DATA_WIDTH],
                                       hit_s ? write_strobe[p*BYTES +: BYTES]
                                             : {BYTES{1'b0}});
            end
            next_s = ((state_r == CLEAR) && (clear_index_r == ENTRY))
                     ? {DATA_WIDTH{1'b0}} : merged_s;
        end

        // Storage flop for this entry (intentionally not reset).
        always_ff @(posedge clock) begin
            mem_r[e] <= next_s;
        end
    end

    // Combinational read ports with optional same-cycle write overlay.
    for (genvar r = 0; r < READ_PORTS; r++) begin : g_read
        logic [ADDR_WIDTH-1:0] addr_s;
        logic [DATA_WIDTH-1:0] value_s;
        logic [DATA_WIDTH-1:0] out_s;
        logic                  hit_s;

        // Stored value, overlaid by this cycle's writes when bypass is built in;
        // forced to zero while not ready and for the hard-wired zero entry.
        always_comb begin
            addr_s  = read_address[r*ADDR_WIDTH +: ADDR_WIDTH];
            value_s = mem_r[addr_s];
            hit_s   = 1'b0;
            for (int p = 0; p < WRITE_PORTS; p++) begin
                hit_s = (BYPASS != 0) && write_enabled[p] &&
                        (write_address[p*ADDR_WIDTH +: ADDR_WIDTH] == addr_s);
                value_s = merge_bytes(value_s,
                                      write_data[p*DATA_WIDTH +: DATA_WIDTH],
                                      hit_s ? write_strobe[p*BYTES +: BYTES]
                                            : {BYTES{1'b0}});
            end
            out_s = (!ready_r || ((ZERO_REG != 0) && (addr_s == ZERO_ADDR)))
                    ? {DATA_WIDTH{1'b0}} : value_s;
        end

        assign read_data[r*DATA_WIDTH +: DATA_WIDTH] = out_s;
    end

endmodule

// File: tb/tb_register_file_multiport.sv
// Testbench for register_file_multiport: two instances (bypass off / on) share
// stimulus; a word-array reference model predicts every read and the ready flag.

module tb_register_file_multiport;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int RP    = 3;
    localparam int WP    = 2;
    localparam int SB    = DW / 8;
    localparam int DEPTH = 32;

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic             clear_request = 1'b0;
    logic [RP*AW-1:0] read_address = '0;
    logic [WP-1:0]    write_enabled = '0;
    logic [WP*SB-1:0] write_strobe = '0;
    logic [WP*AW-1:0] write_address = '0;
    logic [WP*DW-1:0] write_data = '0;
    logic [RP*DW-1:0] rd0;
    logic [RP*DW-1:0] rd1;
    logic             ready0;
    logic             ready1;

    logic [DW-1:0]    mem_m [DEPTH];
    bit               ready_m = 1'b0;
    int               clear_pos = 0;
    int               n_cmp = 0;
    int               n_bad = 0;

    always #5 clock = ~clock;

    register_file_multiport #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_PORTS(RP), .WRITE_PORTS(WP),
        .BYPASS(0), .ZERO_REG(1)
    ) dut0 (
        .clock(clock), .reset(reset), .clear_request(clear_request), .ready(ready0),
        .read_address(read_address), .read_data(rd0), .write_enabled(write_enabled),
        .write_strobe(write_strobe), .write_address(write_address), .write_data(write_data)
    );

    register_file_multiport #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_PORTS(RP), .WRITE_PORTS(WP),
        .BYPASS(1), .ZERO_REG(1)
    ) dut1 (
        .clock(clock), .reset(reset), .clear_request(clear_request), .ready(ready1),
        .read_address(read_address), .read_data(rd1), .write_enabled(write_enabled),
        .write_strobe(write_strobe), .write_address(write_address), .write_data(write_data)
    );

    // Expected read value for the current inputs.
    function automatic logic [DW-1:0] exp_read(input bit bypass, input logic [AW-1:0] addr);
        logic [DW-1:0] v;
        v = mem_m[addr];
        if (bypass) begin
            for (int p = 0; p < WP; p++)
                for (int b = 0; b < SB; b++)
                    if (write_enabled[p] && write_address[p*AW +: AW] == addr && write_strobe[p*SB + b])
                        v[b*8 +: 8] = write_data[p*DW + b*8 +: 8];
        end
        if (!ready_m || addr == 5'd0) v = 32'h0;
        return v;
    endfunction

    // Advance one clock edge and apply the same edge to the model.
    task automatic tick();
        @(posedge clock);
        if (!reset) begin
            ready_m = 1'b0;
            clear_pos = 0;
        end else if (!ready_m) begin
            mem_m[clear_pos] = 32'h0;
            clear_pos++;
            if (clear_pos == DEPTH) ready_m = 1'b1;
        end else begin
            for (int p = 0; p < WP; p++)
                for (int b = 0; b < SB; b++)
                    if (write_enabled[p] && write_strobe[p*SB + b] && write_address[p*AW +: AW] != 5'd0)
                        mem_m[write_address[p*AW +: AW]][b*8 +: 8] = write_data[p*DW + b*8 +: 8];
            if (clear_request) begin
                ready_m = 1'b0;
                clear_pos = 0;
            end
        end
        #1;
    endtask

    task automatic drive_idle();
        write_enabled = '0;
        write_strobe  = '0;
        clear_request = 1'b0;
    endtask

    task automatic drive_random(input int amax);
        for (int p = 0; p < WP; p++) begin
            write_enabled[p]            = 1'($urandom_range(0, 1));
            write_strobe[p*SB +: SB]    = 4'($urandom);
            write_address[p*AW +: AW]   = 5'($urandom_range(0, amax));
            write_data[p*DW +: DW]      = 32'($urandom);
        end
        for (int r = 0; r < RP; r++) read_address[r*AW +: AW] = 5'($urandom_range(0, amax));
    endtask

    task automatic set_reads(input int a);
        for (int r = 0; r < RP; r++) read_address[r*AW +: AW] = 5'((a + r) % DEPTH);
    endtask

    task automatic test_reset();
        logic [DW-1:0] zero = 32'h0;
        drive_idle();
        set_reads(4);
        #12;
        n_cmp += 2;
        if (ready0 !== 1'b0) begin n_bad++; $display("FAIL reset_ready0: got %b expected 0", ready0); end
        if (ready1 !== 1'b0) begin n_bad++; $display("FAIL reset_ready1: got %b expected 0", ready1); end
        @(posedge clock); #1;
        reset = 1'b1;
        ready_m = 1'b0;
        clear_pos = 0;
        for (int i = 0; i < DEPTH; i++) begin
            drive_random(31);
            clear_request = 1'($urandom_range(0, 1));
            @(negedge clock);
            n_cmp += 2;
            if (ready0 !== 1'b0 || ready1 !== 1'b0) begin
                n_bad++; $display("FAIL init_clear_ready cycle %0d: got %b/%b expected 0", i, ready0, ready1);
            end
            if (rd0 !== '0 || rd1 !== '0) begin
                n_bad++; $display("FAIL init_clear_reads cycle %0d: got %h/%h expected 0", i, rd0, rd1);
            end
            tick();
        end
        drive_idle();
        for (int a = 0; a < DEPTH; a += RP) begin
            set_reads(a);
            @(negedge clock);
            n_cmp += 1;
            if (ready0 !== 1'b1 || ready1 !== 1'b1) begin
                n_bad++; $display("FAIL init_ready: got %b/%b expected 1", ready0, ready1);
            end
            for (int r = 0; r < RP; r++) begin
                n_cmp += 2;
                if (rd0[r*DW +: DW] !== zero) begin n_bad++; $display("FAIL init_zero0 addr %0d: got %h expected %h", (a + r) % DEPTH, rd0[r*DW +: DW], zero); end
                if (rd1[r*DW +: DW] !== zero) begin n_bad++; $display("FAIL init_zero1 addr %0d: got %h expected %h", (a + r) % DEPTH, rd1[r*DW +: DW], zero); end
            end
            tick();
        end
    endtask

    task automatic test_strobe();
        logic [DW-1:0] want = 32'hDEADAAEF;
        drive_idle();
        write_enabled = 2'b01;
        write_address[0 +: AW] = 5'd5; write_strobe[0 +: SB] = 4'b1111; write_data[0 +: DW] = 32'hDEADBEEF;
        tick();
        write_strobe[0 +: SB] = 4'b0010; write_data[0 +: DW] = 32'h0000AA00;
        tick();
        drive_idle();
        for (int r = 0; r < RP; r++) read_address[r*AW +: AW] = 5'd5;
        @(negedge clock);
        for (int r = 0; r < RP; r++) begin
            n_cmp += 3;
            if (rd0[r*DW +: DW] !== want) begin n_bad++; $display("FAIL strobe_const0 port %0d: got %h expected %h", r, rd0[r*DW +: DW], want); end
            if (rd1[r*DW +: DW] !== want) begin n_bad++; $display("FAIL strobe_const1 port %0d: got %h expected %h", r, rd1[r*DW +: DW], want); end
            if (rd0[r*DW +: DW] !== exp_read(1'b0, 5'd5)) begin n_bad++; $display("FAIL strobe_model port %0d: got %h expected %h", r, rd0[r*DW +: DW], exp_read(1'b0, 5'd5)); end
        end
        tick();
    endtask

    task automatic test_bypass();
        logic [DW-1:0] old_v = 32'hCAFEF00D;
        logic [DW-1:0] new_v = 32'h12345678;
        drive_idle();
        write_enabled = 2'b01;
        write_address[0 +: AW] = 5'd7; write_strobe[0 +: SB] = 4'b1111; write_data[0 +: DW] = old_v;
        tick();
        write_data[0 +: DW] = new_v;
        for (int r = 0; r < RP; r++) read_address[r*AW +: AW] = 5'd7;
        @(negedge clock);
        for (int r = 0; r < RP; r++) begin
            n_cmp += 2;
            if (rd0[r*DW +: DW] !== old_v) begin n_bad++; $display("FAIL bypass_off port %0d: got %h expected %h", r, rd0[r*DW +: DW], old_v); end
            if (rd1[r*DW +: DW] !== new_v) begin n_bad++; $display("FAIL bypass_on port %0d: got %h expected %h", r, rd1[r*DW +: DW], new_v); end
        end
        tick();
        drive_idle();
        @(negedge clock);
        n_cmp += 2;
        if (rd0[0 +: DW] !== new_v) begin n_bad++; $display("FAIL bypass_after0: got %h expected %h", rd0[0 +: DW], new_v); end
        if (rd1[0 +: DW] !== new_v) begin n_bad++; $display("FAIL bypass_after1: got %h expected %h", rd1[0 +: DW], new_v); end
        tick();
    endtask

    task automatic test_collision();
        logic [DW-1:0] want = 32'h11112222;
        logic [DW-1:0] old_v;
        drive_idle();
        old_v = mem_m[3];
        write_enabled = 2'b11;
        write_address[0 +: AW] = 5'd3;  write_strobe[0 +: SB] = 4'b1111;  write_data[0 +: DW] = 32'h11111111;
        write_address[AW +: AW] = 5'd3; write_strobe[SB +: SB] = 4'b0011; write_data[DW +: DW] = 32'h22222222;
        for (int r = 0; r < RP; r++) read_address[r*AW +: AW] = 5'd3;
        @(negedge clock);
        n_cmp += 2;
        if (rd1[0 +: DW] !== want) begin n_bad++; $display("FAIL collide_bypass: got %h expected %h", rd1[0 +: DW], want); end
        if (rd0[0 +: DW] !== old_v) begin n_bad++; $display("FAIL collide_old: got %h expected %h", rd0[0 +: DW], old_v); end
        tick();
        drive_idle();
        @(negedge clock);
        for (int r = 0; r < RP; r++) begin
            n_cmp += 2;
            if (rd0[r*DW +: DW] !== want) begin n_bad++; $display("FAIL collide0 port %0d: got %h expected %h", r, rd0[r*DW +: DW], want); end
            if (rd1[r*DW +: DW] !== want) begin n_bad++; $display("FAIL collide1 port %0d: got %h expected %h", r, rd1[r*DW +: DW], want); end
        end
        tick();
    endtask

    task automatic test_zero_reg();
        drive_idle();
        write_enabled = 2'b11;
        for (int p = 0; p < WP; p++) begin
            write_address[p*AW +: AW] = 5'd0; write_strobe[p*SB +: SB] = 4'b1111; write_data[p*DW +: DW] = 32'hFFFFFFFF;
        end
        for (int r = 0; r < RP; r++) read_address[r*AW +: AW] = 5'd0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clock);
            n_cmp += 2;
            if (rd0 !== '0) begin n_bad++; $display("FAIL zero_reg0 step %0d: got %h expected 0", k, rd0); end
            if (rd1 !== '0) begin n_bad++; $display("FAIL zero_reg1 step %0d: got %h expected 0", k, rd1); end
            tick();
            drive_idle();
        end
    endtask

    task automatic test_random();
        logic [AW-1:0] ra;
        logic [DW-1:0] e0;
        logic [DW-1:0] e1;
        for (int i = 0; i < 400; i++) begin
            drive_random(7);
            clear_request = ($urandom_range(0, 99) == 0);
            @(negedge clock);
            n_cmp += 1;
            if (ready0 !== ready_m || ready1 !== ready_m) begin
                n_bad++; $display("FAIL rand_ready cycle %0d: got %b/%b expected %b", i, ready0, ready1, ready_m);
            end
            for (int r = 0; r < RP; r++) begin
                ra = read_address[r*AW +: AW];
                e0 = exp_read(1'b0, ra);
                e1 = exp_read(1'b1, ra);
                n_cmp += 2;
                if (rd0[r*DW +: DW] !== e0) begin n_bad++; $display("FAIL rand_rd0 cycle %0d addr %0d: got %h expected %h", i, ra, rd0[r*DW +: DW], e0); end
                if (rd1[r*DW +: DW] !== e1) begin n_bad++; $display("FAIL rand_rd1 cycle %0d addr %0d: got %h expected %h", i, ra, rd1[r*DW +: DW], e1); end
            end
            tick();
        end
        drive_idle();
        while (!ready_m) tick();
    endtask

    task automatic test_clear();
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < DEPTH / 2; i++) begin
                write_enabled = 2'b11;
                write_address[0 +: AW] = 5'(2 * i);     write_strobe[0 +: SB] = 4'b1111; write_data[0 +: DW] = 32'($urandom);
                write_address[AW +: AW] = 5'(2 * i + 1); write_strobe[SB +: SB] = 4'b1111; write_data[DW +: DW] = 32'($urandom);
                tick();
            end
            write_enabled = 2'b01;
            write_address[0 +: AW] = 5'd9; write_data[0 +: DW] = 32'h9999AAAA;
            clear_request = 1'b1;
            tick();
            drive_idle();
            for (int i = 0; i < (pass == 0 ? DEPTH : 10); i++) begin
                drive_random(31);
                clear_request = 1'($urandom_range(0, 1));
                @(negedge clock);
                n_cmp += 2;
                if (ready0 !== 1'b0 || ready1 !== 1'b0) begin
                    n_bad++; $display("FAIL clear_ready pass %0d cycle %0d: got %b/%b expected 0", pass, i, ready0, ready1);
                end
                if (rd0 !== '0 || rd1 !== '0) begin
                    n_bad++; $display("FAIL clear_reads pass %0d cycle %0d: got %h/%h expected 0", pass, i, rd0, rd1);
                end
                tick();
            end
            drive_idle();
            if (pass == 1) begin
                reset = 1'b0;
                ready_m = 1'b0;
                clear_pos = 0;
                #1;
                n_cmp += 1;
                if (ready0 !== 1'b0 || ready1 !== 1'b0) begin
                    n_bad++; $display("FAIL async_reset_ready: got %b/%b expected 0", ready0, ready1);
                end
                tick();
                reset = 1'b1;
                for (int i = 0; i < DEPTH; i++) begin
                    drive_random(31);
                    @(negedge clock);
                    n_cmp += 1;
                    if (ready0 !== 1'b0 || ready1 !== 1'b0) begin
                        n_bad++; $display("FAIL restart_ready cycle %0d: got %b/%b expected 0", i, ready0, ready1);
                    end
                    tick();
                end
                drive_idle();
            end
            for (int a = 0; a < DEPTH; a += RP) begin
                set_reads(a);
                @(negedge clock);
                n_cmp += 3;
                if (ready0 !== 1'b1 || ready1 !== 1'b1) begin
                    n_bad++; $display("FAIL cleared_ready pass %0d: got %b/%b expected 1", pass, ready0, ready1);
                end
                if (rd0 !== '0) begin n_bad++; $display("FAIL cleared_zero0 pass %0d base %0d: got %h expected 0", pass, a, rd0); end
                if (rd1 !== '0) begin n_bad++; $display("FAIL cleared_zero1 pass %0d base %0d: got %h expected 0", pass, a, rd1); end
                tick();
            end
        end
    endtask

    initial begin
        test_reset();
        test_strobe();
        test_bypass();
        test_collision();
        test_zero_reg();
        test_random();
        test_clear();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
